// File: rtl/bus_xfer_ctrl.sv
// bus_xfer_ctrl: sequencer for the shared 16-bit register bus.
// Accepts MOVE / INC / MOVE_INC / NOP commands through a 2-entry FIFO and drives
// registered one-hot strobes to the bus-attached registers.
// Ports:
//   clk, RSTN                       clock, asynchronous active-low reset
//   req_valid/req_ready             command handshake
//   req_op/req_src/req_dst/req_tag  command fields
//   LDBUS, WR, INC                  one-hot per-register strobes (flop outputs)
//   busy                            FSM active or commands queued
//   done, done_tag, err             completion pulse, its tag, index-error flag
module bus_xfer_ctrl #(
    parameter int unsigned NREG = 8,
    parameter int unsigned IW   = 3,
    parameter int unsigned TW   = 4
) (
    input  logic            clk,
    input  logic            RSTN,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [1:0]      req_op,
    input  logic [IW-1:0]   req_src,
    input  logic [IW-1:0]   req_dst,
    input  logic [TW-1:0]   req_tag,
    output logic [NREG-1:0] LDBUS,
    output logic [NREG-1:0] WR,
    output logic [NREG-1:0] INC,
    output logic            busy,
    output logic            done,
    output logic [TW-1:0]   done_tag,
    output logic            err
);

    localparam logic [1:0] OpMove    = 2'b00;
    localparam logic [1:0] OpInc     = 2'b01;
    localparam logic [1:0] OpMoveInc = 2'b10;
    localparam logic [1:0] OpNop     = 2'b11;

    typedef struct packed {
        logic [1:0]    op;
        logic [IW-1:0] src;
        logic [IW-1:0] dst;
        logic [TW-1:0] tag;
    } cmd_t;

    typedef enum logic [1:0] {StIdle, StXfer, StIncr} state_e;

    function automatic logic [NREG-1:0] onehot(input logic [IW-1:0] idx);
        return NREG'(1) << idx;
    endfunction

    function automatic logic idx_ok(input logic [IW-1:0] idx);
        return 32'(idx) < NREG;
    endfunction

    // ---------------- command FIFO ----------------
    cmd_t       fifo_q [2];
    cmd_t       fifo_d [2];
    logic       wptr_q, wptr_d, rptr_q, rptr_d;
    logic [1:0] cnt_q, cnt_d;
    logic       full, empty, push, pop;
    cmd_t       head;

    state_e state_q, state_d;

    assign full      = (cnt_q == 2'd2);
    assign empty     = (cnt_q == 2'd0);
    assign req_ready = !full;
    // Push is gated on !full alone, so a same-cycle pop never frees a slot early.
    assign push      = req_valid && !full;
    assign pop       = (state_q == StIdle) && !empty;
    assign head      = fifo_q[rptr_q];

    always_comb begin
        fifo_d = fifo_q;
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (push) begin
            fifo_d[wptr_q] = '{op: req_op, src: req_src, dst: req_dst, tag: req_tag};
            wptr_d         = !wptr_q;
        end
        if (pop) begin
            rptr_d = !rptr_q;
        end
        cnt_d = cnt_q + {1'b0, push} - {1'b0, pop};
    end

    always_ff @(posedge clk) begin
        fifo_q <= fifo_d;
    end

    // Head rejected when any index it uses falls outside the register file.
    logic head_bad, head_noact;
    assign head_bad   = (head.op != OpNop) &&
                        (!idx_ok(head.dst) ||
                         (((head.op == OpMove) || (head.op == OpMoveInc)) && !idx_ok(head.src)));
    assign head_noact = (head.op == OpNop) || head_bad;

    // ---------------- current command ----------------
    logic [1:0]    cur_op_q, cur_op_d;
    logic [IW-1:0] cur_src_q, cur_src_d;
    logic [TW-1:0] cur_tag_q, cur_tag_d;

    // ---------------- registered outputs ----------------
    logic [NREG-1:0] ldbus_q, ldbus_d, wr_q, wr_d, inc_q, inc_d;
    logic            done_q, done_d, err_q, err_d;
    logic [TW-1:0]   done_tag_q, done_tag_d;

    // State register (plus everything else that resets)
    always_ff @(posedge clk or negedge RSTN) begin
        if (!RSTN) begin
            state_q    <= StIdle;
            wptr_q     <= 1'b0;
            rptr_q     <= 1'b0;
            cnt_q      <= 2'd0;
            cur_op_q   <= OpNop;
            cur_src_q  <= '0;
            cur_tag_q  <= '0;
            ldbus_q    <= '0;
            wr_q       <= '0;
            inc_q      <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            done_tag_q <= '0;
        end else begin
            state_q    <= state_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            cnt_q      <= cnt_d;
            cur_op_q   <= cur_op_d;
            cur_src_q  <= cur_src_d;
            cur_tag_q  <= cur_tag_d;
            ldbus_q    <= ldbus_d;
            wr_q       <= wr_d;
            inc_q      <= inc_d;
            done_q     <= done_d;
            err_q      <= err_d;
            done_tag_q <= done_tag_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d   = state_q;
        cur_op_d  = cur_op_q;
        cur_src_d = cur_src_q;
        cur_tag_d = cur_tag_q;
        unique case (state_q)
            StIdle: begin
                if (pop) begin
                    cur_op_d  = head.op;
                    cur_src_d = head.src;
                    cur_tag_d = head.tag;
                    if (head_noact)              state_d = StIdle;
                    else if (head.op == OpInc)   state_d = StIncr;
                    else                         state_d = StXfer;
                end
            end
            StXfer:  state_d = (cur_op_q == OpMoveInc) ? StIncr : StIdle;
            StIncr:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Output logic: strobes for the state being entered, registered at the edge
    always_comb begin
        ldbus_d    = '0;
        wr_d       = '0;
        inc_d      = '0;
        done_d     = 1'b0;
        err_d      = 1'b0;
        done_tag_d = done_tag_q;
        unique case (state_q)
            StIdle: begin
                if (pop) begin
                    if (head_noact) begin
                        done_d     = 1'b1;
                        err_d      = head_bad;
                        done_tag_d = head.tag;
                    end else if (head.op == OpInc) begin
                        inc_d = onehot(head.dst);
                    end else begin
                        ldbus_d = onehot(head.src);
                        wr_d    = onehot(head.dst);
                    end
                end
            end
            StXfer: begin
                if (cur_op_q == OpMoveInc) begin
                    // Post-increment of the source, one cycle after its write.
                    inc_d = onehot(cur_src_q);
                end else begin
                    done_d     = 1'b1;
                    done_tag_d = cur_tag_q;
                end
            end
            StIncr: begin
                done_d     = 1'b1;
                done_tag_d = cur_tag_q;
            end
            default: ;
        endcase
    end

    assign LDBUS    = ldbus_q;
    assign WR       = wr_q;
    assign INC      = inc_q;
    assign done     = done_q;
    assign err      = err_q;
    assign done_tag = done_tag_q;
    assign busy     = (state_q != StIdle) || !empty;

endmodule

// File: tb/tb_bus_xfer_ctrl.sv
module tb_bus_xfer_ctrl;

    localparam int N  = 6;
    localparam int IW = 3;
    localparam int TW = 4;

    logic          clk = 1'b0;
    logic          RSTN = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [1:0]    req_op = 2'b11;
    logic [IW-1:0] req_src = '0;
    logic [IW-1:0] req_dst = '0;
    logic [TW-1:0] req_tag = '0;
    logic [N-1:0]  LDBUS, WR, INC;
    logic          busy, done, err;
    logic [TW-1:0] done_tag;

    bus_xfer_ctrl #(.NREG(N), .IW(IW), .TW(TW)) dut (
        .clk      (clk),
        .RSTN     (RSTN),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_op   (req_op),
        .req_src  (req_src),
        .req_dst  (req_dst),
        .req_tag  (req_tag),
        .LDBUS    (LDBUS),
        .WR       (WR),
        .INC      (INC),
        .busy     (busy),
        .done     (done),
        .done_tag (done_tag),
        .err      (err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    logic [4:0]  exp_done [$];   // {err, tag}
    logic [17:0] exp_strb [$];   // {LDBUS, WR, INC}
    int          done_cyc [$];
    logic        saw_not_ready = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [N-1:0] oh(input logic [IW-1:0] idx);
        logic [N-1:0] one;
        one = 1;
        return one << idx;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard monitor, sampled on the falling edge.
    always @(negedge clk) begin
        logic [4:0]  ed;
        logic [17:0] es;
        check_eq("ldbus_onehot0", 32'($onehot0(LDBUS)), 1);
        check_eq("wr_inc_overlap", 32'((|WR) & (|INC)), 0);
        if (req_valid && !req_ready) saw_not_ready = 1'b1;
        if ((LDBUS | WR | INC) != '0) begin
            if (exp_strb.size() == 0) begin
                check_eq("strobe_extra", {14'd0, LDBUS, WR, INC}, 0);
            end else begin
                es = exp_strb.pop_front();
                check_eq("strobe_seq", {14'd0, LDBUS, WR, INC}, {14'd0, es});
            end
        end
        if (done) begin
            done_cyc.push_back(cyc);
            if (exp_done.size() == 0) begin
                check_eq("done_extra", 32'(done), 0);
            end else begin
                ed = exp_done.pop_front();
                check_eq("done_tag", 32'(done_tag), 32'(ed[3:0]));
                check_eq("done_err", 32'(err), 32'(ed[4]));
            end
        end
    end

    // Drive one command (called just after a falling edge); returns one cycle
    // after the accepting edge with req_valid dropped.
    task automatic send(input logic [1:0] op, input logic [IW-1:0] src,
                        input logic [IW-1:0] dst, input logic [TW-1:0] tag);
        logic bad;
        bad = (op != 2'd3) && ((32'(dst) >= N) || ((op != 2'd1) && (32'(src) >= N)));
        exp_done.push_back({bad, tag});
        if (!bad) begin
            case (op)
                2'd0: exp_strb.push_back({oh(src), oh(dst), 6'd0});
                2'd1: exp_strb.push_back({6'd0, 6'd0, oh(dst)});
                2'd2: begin
                    exp_strb.push_back({oh(src), oh(dst), 6'd0});
                    exp_strb.push_back({6'd0, 6'd0, oh(src)});
                end
                default: ;
            endcase
        end
        req_valid = 1'b1;
        req_op    = op;
        req_src   = src;
        req_dst   = dst;
        req_tag   = tag;
        for (int i = 0; i < 100 && !req_ready; i++) @(negedge clk);
        if (!req_ready) check_eq("send_timeout", 32'(req_ready), 1);
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            #1;
            if (exp_done.size() == 0 && !busy && !done) break;
        end
        check_eq("drain_done", exp_done.size(), 0);
        check_eq("drain_strb", exp_strb.size(), 0);
    endtask

    initial begin
        // Reset values
        repeat (2) @(negedge clk);
        check_eq("rst_strobes", {14'd0, LDBUS, WR, INC}, 0);
        check_eq("rst_done", {29'd0, done, err, busy}, 0);
        check_eq("rst_tag", 32'(done_tag), 0);
        check_eq("rst_ready", 32'(req_ready), 1);
        RSTN = 1'b1;
        @(negedge clk);

        // Single MOVE src=2 dst=5 tag=3
        send(2'd0, 3'd2, 3'd5, 4'd3);
        check_eq("mv_e0_ldbus", 32'(LDBUS), 0);
        @(negedge clk);
        check_eq("mv_ldbus", 32'(LDBUS), 32'h04);
        check_eq("mv_wr", 32'(WR), 32'h20);
        check_eq("mv_inc", 32'(INC), 0);
        check_eq("mv_nodone", 32'(done), 0);
        @(negedge clk);
        check_eq("mv_done", 32'(done), 1);
        check_eq("mv_tag", 32'(done_tag), 3);
        check_eq("mv_err", 32'(err), 0);
        check_eq("mv_strb_off", {14'd0, LDBUS, WR, INC}, 0);
        check_eq("mv_busy", 32'(busy), 0);
        @(negedge clk);
        check_eq("mv_done_pulse", 32'(done), 0);

        // MOVE_INC src=1 dst=4 tag=5
        send(2'd2, 3'd1, 3'd4, 4'd5);
        @(negedge clk);
        check_eq("mi_xfer", {14'd0, LDBUS, WR, INC}, {14'd0, 6'h02, 6'h10, 6'h00});
        @(negedge clk);
        check_eq("mi_incr", {14'd0, LDBUS, WR, INC}, {14'd0, 6'h00, 6'h00, 6'h02});
        check_eq("mi_nodone", 32'(done), 0);
        @(negedge clk);
        check_eq("mi_done", 32'(done), 1);
        check_eq("mi_tag", 32'(done_tag), 5);
        drain();

        // Backpressure: four MOVEs back to back
        saw_not_ready = 1'b0;
        done_cyc.delete();
        for (int i = 0; i < 4; i++) send(2'd0, 3'(i), 3'(i + 1), 4'(i));
        drain();
        check_eq("bp_ready_drop", 32'(saw_not_ready), 1);
        check_eq("bp_ndone", done_cyc.size(), 4);
        for (int i = 1; i < done_cyc.size(); i++)
            check_eq("bp_spacing", 32'(done_cyc[i] - done_cyc[i-1]), 2);

        // Invalid indices
        send(2'd0, 3'd7, 3'd0, 4'd9);
        @(negedge clk);
        check_eq("inv_done", {30'd0, done, err}, 32'b11);
        check_eq("inv_tag", 32'(done_tag), 9);
        check_eq("inv_strb", {14'd0, LDBUS, WR, INC}, 0);
        send(2'd1, 3'd0, 3'd0, 4'd10);
        @(negedge clk);
        check_eq("inv_next_inc", 32'(INC), 32'h01);
        @(negedge clk);
        check_eq("inv_next_err", {30'd0, done, err}, 32'b10);
        send(2'd1, 3'd0, 3'd6, 4'd11);
        send(2'd2, 3'd6, 3'd1, 4'd12);
        drain();

        // Mixed stream
        send(2'd3, 3'd0, 3'd0, 4'd13);
        send(2'd1, 3'd0, 3'd3, 4'd14);
        send(2'd0, 3'd3, 3'd3, 4'd15);
        send(2'd2, 3'd2, 3'd2, 4'd1);
        drain();

        // Reset in the middle of an XFER with a command still queued
        send(2'd0, 3'd0, 3'd1, 4'd2);
        send(2'd1, 3'd0, 3'd5, 4'd4);
        check_eq("rx_ldbus", 32'(LDBUS), 32'h01);
        #2;
        RSTN = 1'b0;
        #1;
        check_eq("rx_strobes", {14'd0, LDBUS, WR, INC}, 0);
        check_eq("rx_busy", 32'(busy), 0);
        check_eq("rx_ready", 32'(req_ready), 1);
        exp_done.delete();
        exp_strb.delete();
        @(negedge clk);
        RSTN = 1'b1;
        @(negedge clk);
        check_eq("rx_post_busy", 32'(busy), 0);
        send(2'd0, 3'd4, 3'd2, 4'd7);
        drain();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
